instr_fetch_queue: RTL

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Instruction fetch front end. It issues sequential reads to a fixed-latency
//   instruction memory, tracks the reads that are in flight, and buffers the
//   returned words in a small FIFO that the processor drains. A redirect
//   (branch or jump) flushes the FIFO, changes the fetch PC and invalidates
//   every read that is still in flight.
//
// Parameters
//   QUEUE_DEPTH  FIFO entries. Must be a power of two and >= MEM_LATENCY+2.
//   MEM_LATENCY  Cycles from a read request to its data on imem_data.
//   RESET_PC     Address of the first fetch after reset.
//
// Ports
//   clk_in          clock; all state changes on its rising edge
//   rst_in          asynchronous reset, active low
//   imem_rd         read request to instruction memory (combinational)
//   imem_addr       byte address of the read; always the fetch PC
//   imem_data       read data, valid MEM_LATENCY cycles after the request
//   redirect_valid  processor requests a PC change
//   redirect_pc     redirect target (low two bits ignored)
//   inst_valid      FIFO head is valid
//   inst_ready      processor accepts the FIFO head
//   instruction     instruction word at the FIFO head
//   pc_out          byte address of the FIFO head
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int          QUEUE_DEPTH = 4,
    parameter int          MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        imem_rd,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
);

    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic        ep;
    } pipe_t;

    logic [31:0]   fpc_q, fpc_d;
    logic          epoch_q, epoch_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   cnt_q, cnt_d;
    pipe_t         pipe_q [MEM_LATENCY];
    pipe_t         pipe_d [MEM_LATENCY];

    // FIFO storage (data only, no reset needed: cnt_q qualifies it)
    logic [31:0]   q_pc_q  [QUEUE_DEPTH];
    logic [31:0]   q_ins_q [QUEUE_DEPTH];

    int            outst;
    logic          enq;
    logic          deq;

    // Reads in flight. Redirect clears the pipeline, so every valid entry
    // here will land in the FIFO and must hold a credit.
    always_comb begin
        outst = 0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            if (pipe_q[i].vld) outst = outst + 1;
        end
    end

    // Credit rule: only issue when a slot is guaranteed for the response.
    assign imem_rd   = rst_in && !redirect_valid &&
                       ((int'(cnt_q) + outst) < QUEUE_DEPTH);
    assign imem_addr = fpc_q;

    // Redirect wins over a same-cycle enqueue and dequeue.
    assign enq = !redirect_valid && pipe_q[MEM_LATENCY-1].vld &&
                 (pipe_q[MEM_LATENCY-1].ep == epoch_q);
    assign inst_valid  = (cnt_q != '0);
    assign deq         = inst_valid && inst_ready && !redirect_valid;
    assign instruction = inst_valid ? q_ins_q[head_q] : '0;
    assign pc_out      = inst_valid ? q_pc_q[head_q]  : '0;

    always_comb begin
        fpc_d   = fpc_q;
        epoch_d = epoch_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;

        pipe_d[0].vld = imem_rd;
        pipe_d[0].pc  = fpc_q;
        pipe_d[0].ep  = epoch_q;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (redirect_valid) begin
            fpc_d   = redirect_pc & 32'hFFFF_FFFC;
            epoch_d = ~epoch_q;
            head_d  = '0;
            tail_d  = '0;
            cnt_d   = '0;
            // Dropping in-flight valids as well as toggling the epoch keeps
            // back-to-back redirects from aliasing the 1-bit epoch.
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_d[i].vld = 1'b0;
            end
        end else begin
            if (imem_rd) fpc_d  = fpc_q + 32'd4;   // wraps mod 2^32
            if (enq)     tail_d = tail_q + 1'b1;
            if (deq)     head_d = head_q + 1'b1;
            case ({enq, deq})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fpc_q   <= RESET_PC;
            epoch_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            fpc_q   <= fpc_d;
            epoch_q <= epoch_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq) begin
            q_pc_q[tail_q]  <= pipe_q[MEM_LATENCY-1].pc;
            q_ins_q[tail_q] <= imem_data;
        end
    end

endmodule
